encoder8to3_by2_encoder4to2: RTL and testbench



---
 rtl/encoder8to3_by2_encoder4to2_pkg.sv | 12 +
 rtl/encoder8to3_by2_encoder4to2_if.sv | 25 ++
 rtl/encoder8to3_by2_encoder4to2_encoder4to2.sv | 25 ++
 rtl/encoder8to3_by2_encoder4to2.sv | 55 +++++
 tb/tb_encoder8to3_by2_encoder4to2.sv | 117 +++++++++++
 5 files changed

// File: rtl/encoder8to3_by2_encoder4to2_pkg.sv
// Shared widths and types for the 8-to-3 priority encoder.
// Imported by the interface, the 4-to-2 half encoder and the top.
package encoder_pkg;

  localparam int ENC_IN_W   = 8;
  localparam int ENC_OUT_W  = 3;
  localparam int ENC_HALF_W = 4;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage

// File: rtl/encoder8to3_by2_encoder4to2_if.sv
// Encoder bus: request vector w in; index Y, valid, multi out.
// master drives w; slave (the encoder) drives the results.
interface encoder8to3_by2_encoder4to2_if;
  import encoder_pkg::*;

  enc_in_t  w;
  enc_idx_t Y;
  logic     valid;
  logic     multi;

  modport master (
    output w,
    input  Y,
    input  valid,
    input  multi
  );

  modport slave (
    input  w,
    output Y,
    output valid,
    output multi
  );

endinterface

// File: rtl/encoder8to3_by2_encoder4to2_encoder4to2.sv
// Combinational 4-to-2 priority encoder, highest bit wins.
// Ports: d[3:0] in; y[1:0] index out; any = some bit set.
module encoder4to2
  import encoder_pkg::*;
(
  input  logic [ENC_HALF_W-1:0] d,
  output logic [1:0]            y,
  output logic                  any
);

  // Several bits may be set at once, so this is a
  // priority (not unique) selection on the highest one.
  always_comb begin
    y   = 2'd0;
    any = 1'b0;
    priority case (1'b1)
      d[3]: begin y = 2'd3; any = 1'b1; end
      d[2]: begin y = 2'd2; any = 1'b1; end
      d[1]: begin y = 2'd1; any = 1'b1; end
      d[0]: begin y = 2'd0; any = 1'b1; end
      default: begin y = 2'd0; any = 1'b0; end
    endcase
  end

endmodule

// File: rtl/encoder8to3_by2_encoder4to2.sv
// Registered 8-to-3 priority encoder from two 4-to-2 halves.
// Ports: clk, rst (sync, high); bus.slave carries w, Y, valid, multi.
module encoder8to3_by2_encoder4to2
  import encoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  encoder8to3_by2_encoder4to2_if.slave bus
);

  logic [1:0] lo_y;
  logic [1:0] hi_y;
  logic       lo_any;
  logic       hi_any;

  enc_idx_t y_d;
  logic     valid_d;
  logic     multi_d;
  enc_in_t  w_clr;

  encoder4to2 u_lo (
    .d   (bus.w[ENC_HALF_W-1:0]),
    .y   (lo_y),
    .any (lo_any)
  );

  encoder4to2 u_hi (
    .d   (bus.w[ENC_IN_W-1:ENC_HALF_W]),
    .y   (hi_y),
    .any (hi_any)
  );

  // Clearing the lowest set bit leaves something only
  // when two or more bits were set.
  assign w_clr = bus.w & (bus.w - enc_in_t'(1));

  always_comb begin
    y_d     = {hi_any, (hi_any ? hi_y : lo_y)};
    valid_d = hi_any | lo_any;
    multi_d = |w_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Y     <= '0;
      bus.valid <= 1'b0;
      bus.multi <= 1'b0;
    end else begin
      bus.Y     <= y_d;
      bus.valid <= valid_d;
      bus.multi <= multi_d;
    end
  end

endmodule

// File: tb/tb_encoder8to3_by2_encoder4to2.sv
// Self-checking bench: directed cases plus random w vs. a model.
// Model counts set bits and finds the highest one by scanning.
module tb_encoder8to3_by2_encoder4to2;
  import encoder_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  encoder8to3_by2_encoder4to2_if bus ();

  encoder8to3_by2_encoder4to2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input  logic [7:0] v,
                                    input  bit         r,
                                    output logic [2:0] y,
                                    output bit         vl,
                                    output bit         m);
    int n;
    n = 0;
    y = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        y = 3'(i);
        n++;
      end
    end
    vl = (n > 0);
    m  = (n >= 2);
    if (r) begin
      y  = 3'd0;
      vl = 1'b0;
      m  = 1'b0;
    end
  endfunction

  // Drive one cycle, then check the registered result #1 after the edge.
  task automatic apply(input string tag,
                       input logic [7:0] v,
                       input bit r);
    logic [2:0] ey;
    bit ev;
    bit em;
    bus.w = v;
    rst   = r;
    ref_model(v, r, ey, ev, em);
    @(posedge clk);
    #1;
    chk({tag, ".Y"}, 8'(bus.Y), 8'(ey));
    chk({tag, ".valid"}, 8'(bus.valid), 8'(ev));
    chk({tag, ".multi"}, 8'(bus.multi), 8'(em));
  endtask

  initial begin
    logic [7:0] v;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.w  = 8'hFF;

    apply("rst0", 8'hFF, 1'b1);
    apply("rst1", 8'hFF, 1'b1);

    apply("zero", 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      v = 8'h01 << k;
      apply($sformatf("onehot%0d", k), v, 1'b0);
      chk($sformatf("onehot%0d.idx", k), 8'(bus.Y), 8'(k));
    end

    apply("cross", 8'b0001_1000, 1'b0);
    chk("cross.idx", 8'(bus.Y), 8'd4);
    apply("all", 8'hFF, 1'b0);
    chk("all.idx", 8'(bus.Y), 8'd7);
    apply("lohalf", 8'b0000_0101, 1'b0);
    chk("lohalf.idx", 8'(bus.Y), 8'd2);
    apply("ex", 8'b0010_0110, 1'b0);
    chk("ex.idx", 8'(bus.Y), 8'd5);

    apply("b2b0", 8'h80, 1'b0);
    apply("b2b1", 8'h01, 1'b0);
    chk("b2b1.valid_held", 8'(bus.valid), 8'd1);

    apply("midrst", 8'h40, 1'b1);
    chk("midrst.idx", 8'(bus.Y), 8'd0);
    apply("postrst", 8'h40, 1'b0);
    chk("postrst.idx", 8'(bus.Y), 8'd6);

    for (int n = 0; n < 300; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 8'h01 << $urandom_range(0, 7);
      apply("rand", v, ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
